// File: rtl/flag_hs_pkg.sv
// Shared definitions for the toggle-based flag handshake sender.
package flag_hs_pkg;

  localparam logic HS_IDLE         = 1'b0;
  localparam logic HS_WAIT_ACK     = 1'b1;
  localparam int   SYNC_STAGES_MIN = 2;

  typedef enum logic {
    ST_IDLE     = HS_IDLE,
    ST_WAIT_ACK = HS_WAIT_ACK
  } hs_state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-flop single-bit synchronizer, all stages reset to 0.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] sync_p;

  // Shift the asynchronous input through the synchronizer chain every edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], D};
    end
  end

  assign Q = sync_p[STAGES-1];

endmodule

// File: rtl/flag_handshake_tx.sv
// Sending end of an acknowledged toggle handshake: each accepted flag becomes
// one REQ_TOGGLE level change, flags arriving mid-handshake are queued in a
// saturating counter and sent once the echo comes back on ACK_TOGGLE.
// SYNC_STAGES must be at least SYNC_STAGES_MIN.
module flag_handshake_tx
  import flag_hs_pkg::*;
#(
  parameter int PENDING_WIDTH = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     CLK_CE,
  input  logic                     FLAG_IN,
  output logic                     REQ_TOGGLE,
  input  logic                     ACK_TOGGLE,
  input  logic                     CLEAR_OVERFLOW,
  output logic                     BUSY,
  output logic [PENDING_WIDTH-1:0] PENDING,
  output logic                     FLAG_DONE,
  output logic                     OVERFLOW
);

  localparam logic [PENDING_WIDTH-1:0] PENDING_MAX = '1;
  localparam logic [PENDING_WIDTH-1:0] PENDING_ONE = PENDING_WIDTH'(1);

  hs_state_t state;
  logic      ack_s;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .D       (ACK_TOGGLE),
    .Q       (ack_s)
  );

  // Handshake FSM with pending counter, sticky overflow and done pulse.
  // In IDLE a queued flag is always sent before a new one is counted, so an
  // incoming flag with a non-empty queue is "one out, one in". The acknowledge
  // cycle never sends: any flag seen then is queued and leaves from IDLE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      REQ_TOGGLE <= 1'b0;
      PENDING    <= '0;
      FLAG_DONE  <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      FLAG_DONE <= 1'b0;
      if (CLK_CE) begin
        if (CLEAR_OVERFLOW) begin
          OVERFLOW <= 1'b0;
        end
        case (state)
          ST_IDLE: begin
            if (FLAG_IN || (PENDING != '0)) begin
              REQ_TOGGLE <= ~REQ_TOGGLE;
              state      <= ST_WAIT_ACK;
              if (!FLAG_IN) begin
                PENDING <= PENDING - PENDING_ONE;
              end
            end
          end
          ST_WAIT_ACK: begin
            if (FLAG_IN) begin
              if (PENDING == PENDING_MAX) begin
                OVERFLOW <= 1'b1;
              end else begin
                PENDING <= PENDING + PENDING_ONE;
              end
            end
            if (ack_s == REQ_TOGGLE) begin
              FLAG_DONE <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign BUSY = (state == ST_WAIT_ACK);

endmodule

// File: tb/tb_flag_handshake_tx.sv
// Scoreboard bench for flag_handshake_tx with a REQ->ACK loopback of lb_d cycles.
module tb_flag_handshake_tx;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CLK_CE = 1'b1;
  logic       FLAG_IN = 1'b0;
  logic       REQ_TOGGLE;
  logic       ACK_TOGGLE;
  logic       CLEAR_OVERFLOW = 1'b0;
  logic       BUSY;
  logic [3:0] PENDING;
  logic       FLAG_DONE;
  logic       OVERFLOW;

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  ev_t   q_tog[$];
  ev_t   q_done[$];
  ev_t   mon_e;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    lb_d = 3;
  logic  ce_div = 1'b0;
  logic  exp_req = 1'b0;
  logic  prev_req = 1'b0;
  logic [31:0] lb_pipe;

  flag_handshake_tx #(
    .PENDING_WIDTH (4),
    .SYNC_STAGES   (2)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .CLK_CE         (CLK_CE),
    .FLAG_IN        (FLAG_IN),
    .REQ_TOGGLE     (REQ_TOGGLE),
    .ACK_TOGGLE     (ACK_TOGGLE),
    .CLEAR_OVERFLOW (CLEAR_OVERFLOW),
    .BUSY           (BUSY),
    .PENDING        (PENDING),
    .FLAG_DONE      (FLAG_DONE),
    .OVERFLOW       (OVERFLOW)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Receiver model: echoes REQ_TOGGLE after lb_d edges, reset with the DUT.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) lb_pipe <= '0;
    else          lb_pipe <= {lb_pipe[30:0], REQ_TOGGLE};
  end
  assign ACK_TOGGLE = lb_pipe[lb_d-1];

  // Clock-enable pattern: always on, or every 4th edge.
  always @(negedge CLK) CLK_CE = ce_div ? (((cyc + 1) % 4) == 0) : 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected events whenever the DUT presents a toggle or done pulse.
  always @(negedge CLK) begin
    if (!RESET_N) begin
      prev_req = REQ_TOGGLE;
    end else begin
      if (REQ_TOGGLE !== prev_req) begin
        if (q_tog.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_toggle: unexpected change to %0b at cycle %0d", REQ_TOGGLE, cyc);
        end else begin
          mon_e = q_tog.pop_front();
          chk("req_toggle_cycle", cyc, mon_e.cyc);
          chk("req_toggle_value", int'(REQ_TOGGLE), int'(mon_e.val));
        end
      end
      prev_req = REQ_TOGGLE;
      if (FLAG_DONE === 1'b1) begin
        if (q_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL flag_done: unexpected pulse at cycle %0d", cyc);
        end else begin
          mon_e = q_done.pop_front();
          chk("flag_done_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_ev(input int tog_cyc, input int done_cyc);
    exp_req = ~exp_req;
    q_tog.push_back('{tog_cyc, exp_req});
    q_done.push_back('{done_cyc, 1'b1});
  endtask

  // n handshakes, first request at t0, spaced by period; done one edge before next.
  task automatic push_hs(input int t0, input int n, input int period);
    for (int k = 0; k < n; k++) push_ev(t0 + period * k, t0 + period * k + period - 1);
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = 0;
    while (((q_tog.size() != 0) || (q_done.size() != 0)) && (b < budget)) begin
      tick();
      b++;
    end
    checks++;
    if ((q_tog.size() != 0) || (q_done.size() != 0)) begin
      errors++;
      $display("FAIL drain: %0d toggles and %0d done pulses outstanding, expected 0",
               q_tog.size(), q_done.size());
    end
    repeat (10) tick();
  endtask

  initial begin
    int n, m, busy_cnt, maxp, drops;
    repeat (3) tick();
    chk("reset_req", int'(REQ_TOGGLE), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_pending", int'(PENDING), 0);
    chk("reset_done", int'(FLAG_DONE), 0);
    chk("reset_overflow", int'(OVERFLOW), 0);
    RESET_N = 1'b1;
    repeat (3) tick();

    // Single flag, D=3: request one edge after flag, 6 busy cycles.
    lb_d = 3;
    FLAG_IN = 1'b1;
    n = cyc + 1;
    push_hs(n, 1, 7);
    tick();
    FLAG_IN = 1'b0;
    busy_cnt = 0;
    maxp = 0;
    for (int i = 0; i < 10; i++) begin
      busy_cnt += int'(BUSY);
      if (int'(PENDING) > maxp) maxp = int'(PENDING);
      tick();
    end
    chk("single_busy_cycles", busy_cnt, 6);
    chk("single_pending_max", maxp, 0);
    wait_drain(100);

    // Five back-to-back flags, D=3.
    FLAG_IN = 1'b1;
    n = cyc + 1;
    push_hs(n, 5, 7);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i > 0) chk("b2b_pending", int'(PENDING), i);
    end
    FLAG_IN = 1'b0;
    wait_drain(200);
    chk("b2b_pending_end", int'(PENDING), 0);

    // Twenty flags, D=10: saturation, three drops, 17 requests.
    lb_d = 10;
    FLAG_IN = 1'b1;
    n = cyc + 1;
    push_hs(n, 17, 14);
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      if (PENDING == 4'd15) drops++;
      tick();
    end
    FLAG_IN = 1'b0;
    chk("sat_drop_count", drops, 3);
    chk("sat_overflow", int'(OVERFLOW), 1);
    wait_drain(1000);
    chk("sat_pending_end", int'(PENDING), 0);
    chk("sat_overflow_sticky", int'(OVERFLOW), 1);
    CLEAR_OVERFLOW = 1'b1;
    tick();
    CLEAR_OVERFLOW = 1'b0;
    chk("clear_overflow", int'(OVERFLOW), 0);

    // Clock enable every 4th edge; flags on non-CE edges are ignored.
    lb_d = 3;
    ce_div = 1'b1;
    while (((cyc + 1) % 4) != 3) tick();
    FLAG_IN = 1'b1;
    tick();
    m = cyc + 1;
    push_ev(m, m + 8);
    tick();
    tick();
    FLAG_IN = 1'b0;
    chk("ce_pending_ignored", int'(PENDING), 0);
    tick();
    tick();
    FLAG_IN = 1'b1;
    push_ev(m + 12, m + 20);
    tick();
    FLAG_IN = 1'b0;
    chk("ce_pending_queued", int'(PENDING), 1);
    tick();
    chk("ce_pending_hold", int'(PENDING), 1);
    wait_drain(200);
    ce_div = 1'b0;
    tick();

    // Clear in the same cycle as a dropped flag: set wins. D=20.
    lb_d = 20;
    FLAG_IN = 1'b1;
    n = cyc + 1;
    push_hs(n, 16, 24);
    for (int i = 0; i < 16; i++) tick();
    chk("ovf_pending_full", int'(PENDING), 15);
    chk("ovf_not_yet", int'(OVERFLOW), 0);
    CLEAR_OVERFLOW = 1'b1;
    tick();
    FLAG_IN = 1'b0;
    CLEAR_OVERFLOW = 1'b0;
    chk("ovf_set_wins", int'(OVERFLOW), 1);
    chk("ovf_pending_sat", int'(PENDING), 15);
    wait_drain(1500);

    // Reset mid-handshake with three queued flags (OVERFLOW still set).
    lb_d = 10;
    FLAG_IN = 1'b1;
    n = cyc + 1;
    push_ev(n, n + 13);
    repeat (4) tick();
    FLAG_IN = 1'b0;
    chk("rst_pre_pending", int'(PENDING), 3);
    chk("rst_pre_busy", int'(BUSY), 1);
    RESET_N = 1'b0;
    #1;
    chk("rst_req", int'(REQ_TOGGLE), 0);
    chk("rst_pending", int'(PENDING), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_overflow", int'(OVERFLOW), 0);
    q_tog.delete();
    q_done.delete();
    exp_req = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    lb_d = 3;
    FLAG_IN = 1'b1;
    n = cyc + 1;
    push_hs(n, 1, 7);
    tick();
    FLAG_IN = 1'b0;
    chk("post_rst_req", int'(REQ_TOGGLE), 1);
    chk("post_rst_pending", int'(PENDING), 0);
    wait_drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/flag_handshake_tx.md
# flag_handshake_tx

Sending end of a toggle-based, acknowledged flag handshake. The block accepts single-cycle flags in its own clock domain and converts each one into a level change on `REQ_TOGGLE`. It then waits for the far receiver to echo that level back on `ACK_TOGGLE` before it sends the next flag. Flags that arrive while a handshake is outstanding are counted and sent later, so none are lost up to the counter depth. The block sits in any module that must pass event flags to a slower or unrelated clock domain, where a plain toggle synchronizer would merge back-to-back flags.

## Interface
- `PENDING_WIDTH`, default 4: width of the pending-flag counter. At most 2^PENDING_WIDTH−1 flags can be queued.
- `SYNC_STAGES`, default 2: number of synchronizer flip-flops on `ACK_TOGGLE`. Must be ≥ 2.
- `CLK` in 1: the block's only clock.
- `RESET_N` in 1: asynchronous, active-low reset.
- `CLK_CE` in 1: clock enable. The FSM and the counter advance only on edges where this is high.
- `FLAG_IN` in 1: single-cycle flag. Sampled only when `CLK_CE`=1.
- `REQ_TOGGLE` out 1: request level, sent to the far domain.
- `ACK_TOGGLE` in 1: asynchronous echo of `REQ_TOGGLE` from the receiver.
- `CLEAR_OVERFLOW` in 1: clears `OVERFLOW`. Sampled when `CLK_CE`=1.
- `BUSY` out 1: high while a handshake is outstanding.
- `PENDING` out PENDING_WIDTH: number of queued flags not yet sent.
- `FLAG_DONE` out 1: one-cycle pulse when an acknowledge is received.
- `OVERFLOW` out 1: sticky. Set when a flag is dropped.

## Operation
- Reset values: `REQ_TOGGLE`=0, `BUSY`=0, `PENDING`=0, `FLAG_DONE`=0, `OVERFLOW`=0, all synchronizer flops=0, state IDLE.
- The `ACK_TOGGLE` synchronizer clocks on every `CLK` edge; it ignores `CLK_CE`. `ack_s` is the output of its last stage.
- State IDLE (`BUSY`=0), on a CE cycle:
  - If `FLAG_IN`=1 or `PENDING`≠0: invert `REQ_TOGGLE` and go to WAIT_ACK.
  - If the sent flag came from the queue and `FLAG_IN`=1: `PENDING` is unchanged (one out, one in).
  - If the sent flag came from the queue and `FLAG_IN`=0: `PENDING` decrements.
  - If `PENDING`=0: the incoming flag is sent directly and `PENDING` stays 0.
- State WAIT_ACK (`BUSY`=1), on a CE cycle:
  - `FLAG_IN`=1 increments `PENDING`.
  - If `PENDING` is already 2^PENDING_WIDTH−1, the flag is dropped, `OVERFLOW` is set and `PENDING` stays at that value.
  - If `ack_s`=`REQ_TOGGLE`: pulse `FLAG_DONE` and go to IDLE. The next flag is sent no earlier than the following CE cycle.
- `FLAG_IN` during the cycle in which the acknowledge completes is queued (or dropped on overflow, as above). It is never sent in that same cycle.
- `CLEAR_OVERFLOW` and a new overflow in the same cycle: the set wins, so `OVERFLOW` stays 1.
- When `CLK_CE`=0, `REQ_TOGGLE`, `PENDING`, `OVERFLOW` and the state hold.
- `FLAG_DONE` drops to 0 on the next `CLK` edge, even if `CLK_CE`=0.
- Reset asserted mid-handshake: everything returns to its reset value immediately and any queued flags are lost.
- The receiver must be reset together with this block so that `ACK_TOGGLE` is 0 again. If it is not, the first acknowledge after reset is invalid.
- In IDLE, a mismatch between `ack_s` and `REQ_TOGGLE` is ignored.

## Timing
- Latency from flag to request: `FLAG_IN` sampled on CE edge n → `REQ_TOGGLE` changes right after edge n.
- Acknowledge latency: an `ACK_TOGGLE` change reaches `ack_s` after SYNC_STAGES `CLK` edges. `FLAG_DONE` is registered and appears on the next CE edge after that.
- Minimum spacing between successive `REQ_TOGGLE` changes = (receiver round-trip delay) + SYNC_STAGES + 2 cycles when `CLK_CE` is always 1.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Shared package `flag_hs_pkg` holds:
  - the state encoding localparams (`HS_IDLE`=0, `HS_WAIT_ACK`=1);
  - `SYNC_STAGES_MIN`=2.
- Sub-module `cdc_sync_bit` (parameter STAGES, ports CLK, RESET_N, D, Q): an N-flop synchronizer, reset to 0. One instance, on `ACK_TOGGLE`.
- Top level contains: the FSM, the pending counter, the overflow flop and the `FLAG_DONE` register.

## Test plan
All scenarios run with `CLK_CE`=1 unless stated, and with `ACK_TOGGLE` driven by a loopback model: `REQ_TOGGLE` delayed by D cycles.
- Single flag, D=3, SYNC_STAGES=2 → `REQ_TOGGLE` 0→1 one cycle after the flag; `BUSY`=1 for 6 cycles; one `FLAG_DONE` pulse; `PENDING` stays 0.
- Five back-to-back flags, D=3 → `PENDING` goes 1,2,3,4; then exactly 5 `REQ_TOGGLE` changes; `FLAG_DONE` pulses 5 times; `PENDING` ends at 0.
- 20 back-to-back flags, PENDING_WIDTH=4, D=10 → `PENDING` saturates at 15 and `OVERFLOW`=1.
  - Count the flags that arrive while `PENDING`=15 (dropped). Required: number of `REQ_TOGGLE` changes = 20 − that count.
  - `CLEAR_OVERFLOW` issued afterwards clears `OVERFLOW`.
- `CLK_CE` high only every 4th cycle, 2 flags on CE cycles → toggles and `PENDING` change only on CE edges; flags applied while `CLK_CE`=0 are ignored.
- `RESET_N` pulsed low while `BUSY`=1 and `PENDING`=3 → immediately `REQ_TOGGLE`=0, `PENDING`=0, `BUSY`=0, `OVERFLOW`=0; the next flag starts a clean handshake.
- `CLEAR_OVERFLOW` in the same cycle as a dropped flag → `OVERFLOW` remains 1.
